// File: rtl/led_sequencer_if.sv
// Board-pin bundle for led_sequencer: raw buttons in, LED drive and status out.
interface led_sequencer_if;
    logic [1:0] buttons;
    logic [5:0] leds;
    logic [1:0] mode;
    logic       paused;

    modport master (output buttons, input leds, input mode, input paused);
    modport slave  (input buttons, output leds, output mode, output paused);
endinterface

// File: rtl/led_sequencer.sv
// Six-LED pattern sequencer with debounced mode/pause buttons.
// Build option LED_SEQ_INVERT_EN drives the LEDs active-low.
module led_seq_debounce #(
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Rising edge of the debounced level only; releases are silent.
        press_d = db_d & ~db_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

module led_sequencer #(
    parameter int TICK_CYCLES     = 13_500_000,
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic            clk,
    input  logic            rst,
    led_sequencer_if.slave  bus
);
    localparam int NUM_BTN = 2;
    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {BLINK = 2'd0, SHIFT = 2'd1, BOUNCE = 2'd2, COUNT = 2'd3} mode_t;

    logic [NUM_BTN-1:0] press;
    mode_t              mode_q, mode_d;
    logic               paused_q, paused_d;
    logic [5:0]         p_q, p_d;
    logic               dir_up_q, dir_up_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [5:0]         leds_q, leds_d;
    logic               tick;
    logic               up_eff;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.buttons[i]),
            .press (press[i])
        );
    end

    function automatic logic [5:0] init_pat(input mode_t m);
        return (m == SHIFT || m == BOUNCE) ? 6'b000001 : 6'b000000;
    endfunction

    always_comb begin
        mode_d   = mode_q;
        paused_d = paused_q;
        p_d      = p_q;
        dir_up_d = dir_up_q;
        presc_d  = presc_q;
        tick     = !paused_q && (presc_q == TICK_MAX);
        // Bounce turns around at either end before stepping.
        up_eff   = p_q[5] ? 1'b0 : (p_q[0] ? 1'b1 : dir_up_q);

        if (!paused_q) presc_d = tick ? '0 : presc_q + PW'(1);

        if (tick) begin
            unique case (mode_q)
                BLINK:  p_d = ~p_q;
                SHIFT:  p_d = {p_q[4:0], p_q[5]};
                BOUNCE: begin
                    p_d      = up_eff ? {p_q[4:0], 1'b0} : {1'b0, p_q[5:1]};
                    dir_up_d = up_eff;
                end
                COUNT:  p_d = (p_q == 6'd63) ? 6'd0 : p_q + 6'd1;
                default: p_d = p_q;
            endcase
        end

        if (press[1]) paused_d = ~paused_q;

        // A mode step overrides any same-cycle tick.
        if (press[0]) begin
            unique case (mode_q)
                BLINK:   mode_d = SHIFT;
                SHIFT:   mode_d = BOUNCE;
                BOUNCE:  mode_d = COUNT;
                default: mode_d = BLINK;
            endcase
            p_d      = init_pat(mode_d);
            dir_up_d = 1'b1;
            presc_d  = '0;
        end

`ifdef LED_SEQ_INVERT_EN
        leds_d = ~p_q;
`else
        leds_d = p_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= BLINK;
            paused_q <= 1'b0;
            p_q      <= 6'b000000;
            dir_up_q <= 1'b1;
            presc_q  <= '0;
`ifdef LED_SEQ_INVERT_EN
            leds_q   <= 6'b111111;
`else
            leds_q   <= 6'b000000;
`endif
        end else begin
            mode_q   <= mode_d;
            paused_q <= paused_d;
            p_q      <= p_d;
            dir_up_q <= dir_up_d;
            presc_q  <= presc_d;
            leds_q   <= leds_d;
        end
    end

    assign bus.leds   = leds_q;
    assign bus.mode   = mode_q;
    assign bus.paused = paused_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_CYCLES=4, DEBOUNCE_CYCLES=3.
module tb_led_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    led_sequencer_if bus();

    led_sequencer #(.TICK_CYCLES(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] L(input logic [5:0] p);
`ifdef LED_SEQ_INVERT_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0: reset just released, prescaler at 0.
    task automatic do_reset();
        rst = 1'b1;
        bus.buttons = 2'b00;
        #1;
        check("rst_leds", bus.leds, L(6'b000000));
        check("rst_mode", bus.mode, 2'd0);
        check("rst_paused", bus.paused, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Press starting now; returns 6 cycles later (first cycle of new state) with buttons released.
    task automatic press(input logic [1:0] mask);
        bus.buttons = mask;
        step(6);
        bus.buttons = 2'b00;
    endtask

    initial begin
        bus.buttons = 2'b00;
        step(2);

        // Idle BLINK
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            check($sformatf("blink_c%0d", c), bus.leds,
                  L(((c >= 5 && c <= 8) || c >= 13) ? 6'b111111 : 6'b000000));
            check("blink_mode", bus.mode, 2'd0);
            check("blink_paused", bus.paused, 1'b0);
            step(1);
        end

        // Held button 0
        do_reset();
        bus.buttons = 2'b01;
        step(5);
        check("hold_mode_c5", bus.mode, 2'd0);
        step(1);
        check("hold_mode_c6", bus.mode, 2'd1);
        check("hold_leds_c6", bus.leds, L(6'b111111));
        step(1);
        check("hold_leds_c7", bus.leds, L(6'b000001));
        step(3);
        check("hold_leds_c10", bus.leds, L(6'b000001));
        step(1);
        check("hold_leds_c11", bus.leds, L(6'b000010));
        step(4);
        check("hold_leds_c15", bus.leds, L(6'b000100));
        step(25);
        check("hold_mode_c40", bus.mode, 2'd1);
        bus.buttons = 2'b00;

        // Two-cycle glitch is rejected
        do_reset();
        bus.buttons = 2'b01;
        step(2);
        bus.buttons = 2'b00;
        step(10);
        check("glitch2_mode", bus.mode, 2'd0);

        // Three stable cycles is accepted; release is silent
        do_reset();
        bus.buttons = 2'b01;
        step(3);
        bus.buttons = 2'b00;
        step(3);
        check("glitch3_mode_c6", bus.mode, 2'd1);
        step(14);
        check("glitch3_mode_c20", bus.mode, 2'd1);

        // BOUNCE then COUNT
        do_reset();
        press(2'b01);
        step(6);
        press(2'b01);
        check("bounce_mode", bus.mode, 2'd2);
        step(2);
        for (int k = 0; k <= 12; k++) begin
            int pos;
            pos = (k % 10) <= 5 ? (k % 10) : 10 - (k % 10);
            check($sformatf("bounce_k%0d", k), bus.leds, L(6'(1 << pos)));
            step(4);
        end
        press(2'b01);
        check("count_mode", bus.mode, 2'd3);
        step(2);
        for (int k = 0; k <= 65; k++) begin
            if (k <= 2 || k >= 62)
                check($sformatf("count_k%0d", k), bus.leds, L(6'(k % 64)));
            step(4);
        end

        // Pause in SHIFT with frozen count 2, then resume
        do_reset();
        bus.buttons = 2'b01;
        step(2);
        bus.buttons = 2'b11;
        step(4);
        check("pause_mode_c6", bus.mode, 2'd1);
        check("pause_paused_c6", bus.paused, 1'b0);
        step(2);
        bus.buttons = 2'b00;
        check("pause_paused_c8", bus.paused, 1'b1);
        check("pause_leds_c8", bus.leds, L(6'b000001));
        step(20);
        check("pause_leds_c28", bus.leds, L(6'b000001));
        check("pause_paused_c28", bus.paused, 1'b1);
        bus.buttons = 2'b10;
        step(5);
        check("resume_paused_c33", bus.paused, 1'b1);
        step(1);
        bus.buttons = 2'b00;
        check("resume_paused_c34", bus.paused, 1'b0);
        step(2);
        check("resume_leds_c36", bus.leds, L(6'b000001));
        step(1);
        check("resume_leds_c37", bus.leds, L(6'b000010));

        // Simultaneous presses, then reset mid-debounce
        do_reset();
        press(2'b11);
        check("both_mode", bus.mode, 2'd1);
        check("both_paused", bus.paused, 1'b1);
        step(8);
        check("both_leds_c14", bus.leds, L(6'b000001));
        bus.buttons = 2'b01;
        step(3);
        rst = 1'b1;
        #1;
        check("midrst_mode", bus.mode, 2'd0);
        check("midrst_paused", bus.paused, 1'b0);
        check("midrst_leds", bus.leds, L(6'b000000));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(5);
        check("postrst_mode_c5", bus.mode, 2'd0);
        step(1);
        check("postrst_mode_c6", bus.mode, 2'd1);
        bus.buttons = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Board-level LED controller that owns the six user LEDs and sequences them through four selectable patterns. Both push-buttons are synchronised and debounced internally; button 0 steps the pattern mode and button 1 pauses or resumes animation. The block sits between the raw board pins (`buttons`, `leds`) and replaces ad-hoc per-design LED toggling with one scheduled resource.

## Interface
- `TICK_CYCLES`, default 13_500_000: clock cycles per animation step (0.5 s at 27 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 270_000: stable cycles required to accept a button change (10 ms at 27 MHz); must be ≥ 1.
- `clk`  in  1  system clock. One clock domain; all state is clocked on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `buttons`  in  2  raw asynchronous button levels; 1 = pressed.
- `leds`  out  6  registered LED drive.
- `mode`  out  2  current mode: 0 BLINK, 1 SHIFT, 2 BOUNCE, 3 COUNT.
- `paused`  out  1  1 = animation frozen.

## Operation
- Synchroniser: each button passes through two flops before any other use.
- Debounce, per button: keep a debounced state and a counter.
  - When the synced value equals the debounced state, the counter clears to 0.
  - Otherwise the counter increments. When the counter reaches `DEBOUNCE_CYCLES-1`, the debounced state takes the synced value and the counter clears.
- Press event: a one-cycle pulse on the debounced 0→1 transition. A release produces no event.
- Press on button 0: mode advances 0→1→2→3→0. The pattern reloads with the new mode's initial value and the prescaler clears. `paused` is unchanged.
- Press on button 1: toggles `paused`.
- Simultaneous press events on both buttons in the same cycle: both take effect.
- Prescaler: counts 0..`TICK_CYCLES-1` and wraps to 0. A tick is the cycle in which the count equals `TICK_CYCLES-1`. While `paused`=1, the prescaler holds and no ticks occur.
- Pattern update on each tick (6-bit pattern register `p`):
  - BLINK: initial value 000000; each tick, `p` ← ~`p`.
  - SHIFT: initial value 000001; each tick, rotate left by 1 (bit5 wraps to bit0).
  - BOUNCE: initial value 000001 with direction up. A single lit bit moves one position per tick. Direction reverses on reaching bit5 or bit0. The sequence 0,1,2,3,4,5,4,3,2,1,0,1… has a 10-tick period.
  - COUNT: initial value 000000; each tick, `p` ← `p`+1 modulo 64, so 63 wraps to 0.
- A mode change and a tick in the same cycle: the mode change wins. `p` takes the new mode's initial value and the prescaler clears.
- `leds` is registered from `p`: `leds` = `p`, or ~`p` when inversion is configured.

## Timing
- Reset values: `mode`=0, `paused`=0, `p`=000000, `leds`=000000 (111111 with inversion), prescaler=0, synchroniser flops=0, debounced states=0, debounce counters=0.
- Reset takes effect immediately, including mid-debounce or mid-tick. All of the above state returns to its reset value.
- Press latency: a stable raw 0→1 level produces a press pulse 2 + `DEBOUNCE_CYCLES` cycles later. `mode`/`paused` update at the end of the pulse cycle and are visible the next cycle.
- `leds` reflects the new `p` one cycle after `p` updates.
- First tick after reset or a mode change: `TICK_CYCLES` cycles later. Ticks then repeat every `TICK_CYCLES` unpaused cycles.
- Pausing freezes the prescaler count. Resuming continues from the frozen count; it does not restart.
- Bounce shorter than `DEBOUNCE_CYCLES` consecutive stable cycles produces no event.
- Holding a button produces exactly one event.
- Width rules:
  - Prescaler width is `$clog2(TICK_CYCLES)`.
  - Debounce counter width is `$clog2(DEBOUNCE_CYCLES)+1`.
  - All wraps are explicit compares, never reliance on overflow.

## Configuration
- `LED_SEQ_INVERT_EN`
  - Defined: `leds` = ~`p`, and `leds` resets to 111111. This drives active-low board LEDs.
  - Undefined: `leds` = `p`, and `leds` resets to 000000.
  - All other behaviour, including `mode` and `paused`, is identical in both builds.

## Test plan
All scenarios use `TICK_CYCLES`=4 and `DEBOUNCE_CYCLES`=3.
- Reset, then run 13 cycles with no input → `leds` sequence 000000, then 111111, 000000, 111111 with changes every 4 cycles; `mode`=0 and `paused`=0 throughout.
- Hold `buttons[0]`=1 steadily → exactly one press event; `mode`=1 and `leds` shows 000001, then 000010 and 000100 on later ticks. Holding longer produces no further mode change.
- Glitch `buttons[0]` high for 2 cycles, then low → no press event; `mode` stays 0.
- Select BOUNCE and run 12 ticks → lit bit positions 0,1,2,3,4,5,4,3,2,1,0,1,2. Select COUNT and run 65 ticks → `leds` passes through 111111 and wraps to 000000.
- Press `buttons[1]` in SHIFT mode at prescaler count 2 → `paused`=1 and `leds` frozen for 20 cycles. Press again → the next shift occurs 2 cycles after resume (count continues from 2).
- Press both buttons so both events fire in the same cycle → `mode` increments and `paused` toggles together. Assert `rst` mid-debounce → all outputs return to reset values on the same edge.
